// File: rtl/byte_data_memory_if.sv
// Load/store request bus between the CPU datapath and byte_data_memory.
interface byte_data_memory_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
);
  logic                  Req;
  logic                  Ready;
  logic                  MemWrite;
  logic                  ByteMode;
  logic [ADDR_WIDTH-1:0] Address;
  logic [DATA_WIDTH-1:0] WriteData;
  logic [DATA_WIDTH-1:0] ReadData;
  logic                  Done;
  logic                  Error;

  modport master (
    output Req, MemWrite, ByteMode, Address, WriteData,
    input  Ready, ReadData, Done, Error
  );

  modport slave (
    input  Req, MemWrite, ByteMode, Address, WriteData,
    output Ready, ReadData, Done, Error
  );
endinterface

// File: rtl/byte_data_memory.sv
// Byte-addressed big-endian data memory: registered read, byte/word access,
// alignment/range error response and a zero-init sweep after reset or Clear.
module byte_data_memory #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int DEPTH_BYTES = 128
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Clear,
  byte_data_memory_if.slave bus
);
  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned PTR_W = $clog2(DEPTH_BYTES);
  localparam logic [PTR_W-1:0]    LAST_PTR = PTR_W'(DEPTH_BYTES - 1);
  localparam logic [ADDR_WIDTH:0] WORD_SPAN = (ADDR_WIDTH+1)'(BYTES - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_X   = (ADDR_WIDTH+1)'(DEPTH_BYTES);

  typedef enum logic {INIT, RUN} state_t;

  state_t              state, state_nxt;
  logic [PTR_W-1:0]    ptr, ptr_nxt;
  logic [7:0]          mem [DEPTH_BYTES];

  logic                accept;
  logic                misaligned;
  logic                out_of_range;
  logic                err;
  logic [ADDR_WIDTH:0] end_addr;
  logic [PTR_W-1:0]    idx;
  logic [DATA_WIDTH-1:0] rdata;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= INIT;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      INIT: begin
        ptr_nxt = ptr + PTR_W'(1);
        if (ptr == LAST_PTR) state_nxt = RUN;
      end
      RUN: begin
        if (Clear) begin
          state_nxt = INIT;
          ptr_nxt   = '0;
        end
      end
      default: state_nxt = INIT;
    endcase
  end

  assign bus.Ready = (state == RUN) && !Clear;
  assign accept    = bus.Req && bus.Ready;

  // Range check in ADDR_WIDTH+1 bits so a word at the top of the address space cannot wrap.
  assign misaligned   = !bus.ByteMode && ((bus.Address % ADDR_WIDTH'(BYTES)) != '0);
  assign end_addr     = {1'b0, bus.Address} + (bus.ByteMode ? '0 : WORD_SPAN);
  assign out_of_range = end_addr >= DEPTH_X;
  assign err          = misaligned || out_of_range;
  assign idx          = bus.Address[PTR_W-1:0];

  always_comb begin
    rdata = '0;
    if (bus.ByteMode) begin
      rdata[7:0] = mem[idx];
    end else begin
      for (int unsigned i = 0; i < BYTES; i++)
        rdata[DATA_WIDTH-1-8*i -: 8] = mem[idx + PTR_W'(i)];
    end
  end

  // Array has no reset: the INIT sweep is what defines its contents.
  always_ff @(posedge Clock) begin
    if (state == INIT) begin
      mem[ptr] <= '0;
    end else if (accept && bus.MemWrite && !err) begin
      if (bus.ByteMode) begin
        mem[idx] <= bus.WriteData[7:0];
      end else begin
        for (int unsigned i = 0; i < BYTES; i++)
          mem[idx + PTR_W'(i)] <= bus.WriteData[DATA_WIDTH-1-8*i -: 8];
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      bus.Done     <= 1'b0;
      bus.Error    <= 1'b0;
      bus.ReadData <= '0;
    end else begin
      bus.Done  <= accept;
      bus.Error <= accept && err;
      if (accept && !bus.MemWrite && !err) bus.ReadData <= rdata;
    end
  end
endmodule

// File: tb/tb_byte_data_memory.sv
// Directed bench for byte_data_memory with DATA_WIDTH=16, DEPTH_BYTES=128.
module tb_byte_data_memory;
  logic Clock = 1'b0;
  logic Reset;
  logic Clear;
  int   checks = 0;
  int   passed = 0;
  int   fails  = 0;
  int   n;

  byte_data_memory_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) bus ();

  byte_data_memory #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(16),
    .DEPTH_BYTES(128)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .Clear(Clear),
    .bus(bus)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one request for one cycle; on return we are in cycle N+1.
  task automatic issue(input logic mw, input logic bm, input logic [15:0] a, input logic [15:0] wd);
    bus.Req       = 1'b1;
    bus.MemWrite  = mw;
    bus.ByteMode  = bm;
    bus.Address   = a;
    bus.WriteData = wd;
    tick();
    bus.Req = 1'b0;
  endtask

  task automatic expect_resp(input string tag, input logic err, input logic [15:0] rd);
    check({tag, "_done"}, bus.Done, 1'b1);
    check({tag, "_err"}, bus.Error, err);
    check({tag, "_rd"}, bus.ReadData, rd);
  endtask

  task automatic count_sweep(input string tag);
    n = 0;
    while (!bus.Ready && n < 400) begin
      tick();
      n++;
    end
    check(tag, n, 128);
  endtask

  initial begin
    Reset = 1'b1;
    Clear = 1'b0;
    bus.Req = 1'b0; bus.MemWrite = 1'b0; bus.ByteMode = 1'b0;
    bus.Address = '0; bus.WriteData = '0;
    tick(); tick();
    check("rst_ready", bus.Ready, 1'b0);
    check("rst_done", bus.Done, 1'b0);
    check("rst_err", bus.Error, 1'b0);
    check("rst_rd", bus.ReadData, 16'h0000);

    Reset = 1'b0;
    count_sweep("init_len");

    issue(1'b0, 1'b0, 16'h0000, 16'h0000);
    expect_resp("rd0", 1'b0, 16'h0000);
    tick();
    check("done_drop", bus.Done, 1'b0);

    // Endianness
    issue(1'b1, 1'b0, 16'h0010, 16'hA1B2);
    expect_resp("wr10", 1'b0, 16'h0000);
    issue(1'b0, 1'b1, 16'h0010, 16'h0000);
    expect_resp("brd10", 1'b0, 16'h00A1);
    issue(1'b0, 1'b1, 16'h0011, 16'h0000);
    expect_resp("brd11", 1'b0, 16'h00B2);
    issue(1'b0, 1'b0, 16'h0010, 16'h0000);
    expect_resp("wrd10", 1'b0, 16'hA1B2);

    // Byte write touches only one byte
    issue(1'b1, 1'b1, 16'h0021, 16'hEE5C);
    expect_resp("bwr21", 1'b0, 16'hA1B2);
    issue(1'b0, 1'b0, 16'h0020, 16'h0000);
    expect_resp("wrd20", 1'b0, 16'h005C);

    // Misaligned write is rejected and modifies nothing
    issue(1'b1, 1'b0, 16'h0013, 16'hFFFF);
    expect_resp("wr13", 1'b1, 16'h005C);
    issue(1'b0, 1'b0, 16'h0012, 16'h0000);
    expect_resp("rd12", 1'b0, 16'h0000);
    issue(1'b0, 1'b0, 16'h0014, 16'h0000);
    expect_resp("rd14", 1'b0, 16'h0000);
    issue(1'b0, 1'b0, 16'h0011, 16'h0000);
    expect_resp("rd11_mis", 1'b1, 16'h0000);

    // Top-of-memory boundary
    issue(1'b1, 1'b0, 16'h007E, 16'hBEEF);
    expect_resp("wr7e", 1'b0, 16'h0000);
    issue(1'b0, 1'b0, 16'h007E, 16'h0000);
    expect_resp("rd7e", 1'b0, 16'hBEEF);
    issue(1'b0, 1'b0, 16'h0080, 16'h0000);
    expect_resp("rd80", 1'b1, 16'hBEEF);
    issue(1'b0, 1'b1, 16'h007F, 16'h0000);
    expect_resp("brd7f", 1'b0, 16'h00EF);
    issue(1'b0, 1'b1, 16'hFFFF, 16'h0000);
    expect_resp("brdffff", 1'b1, 16'h00EF);

    // Back-to-back write then read of the same word
    bus.Req = 1'b1; bus.MemWrite = 1'b1; bus.ByteMode = 1'b0;
    bus.Address = 16'h0030; bus.WriteData = 16'h1234;
    tick();
    bus.MemWrite = 1'b0;
    check("b2b_done1", bus.Done, 1'b1);
    check("b2b_ready", bus.Ready, 1'b1);
    tick();
    bus.Req = 1'b0;
    expect_resp("b2b_rd", 1'b0, 16'h1234);

    // Clear while a response is pending and a new request is offered
    issue(1'b0, 1'b0, 16'h007E, 16'h0000);
    Clear = 1'b1;
    bus.Req = 1'b1; bus.MemWrite = 1'b0; bus.ByteMode = 1'b0; bus.Address = 16'h0010;
    #1;
    check("clr_ready", bus.Ready, 1'b0);
    check("clr_pending_done", bus.Done, 1'b1);
    check("clr_pending_rd", bus.ReadData, 16'hBEEF);
    tick();
    Clear = 1'b0;
    bus.Req = 1'b0;
    check("clr_no_done", bus.Done, 1'b0);
    count_sweep("clr_len");
    issue(1'b0, 1'b0, 16'h0010, 16'h0000);
    expect_resp("clr_rd10", 1'b0, 16'h0000);

    // Reset during a response drops Done immediately
    issue(1'b0, 1'b0, 16'h0020, 16'h0000);
    check("pre_rst_done", bus.Done, 1'b1);
    Reset = 1'b1;
    #1;
    check("rst_mid_done", bus.Done, 1'b0);
    check("rst_mid_rd", bus.ReadData, 16'h0000);
    tick();
    Reset = 1'b0;

    // Reset again at sweep cycle 50 restarts the sweep
    for (int i = 0; i < 50; i++) tick();
    check("sweep50_ready", bus.Ready, 1'b0);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    count_sweep("rst50_len");
    issue(1'b0, 1'b0, 16'h0030, 16'h0000);
    expect_resp("post_rd30", 1'b0, 16'h0000);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
